itype_instr_gen: RTL and testbench

//  Synthesizable stimulus source: emits a pseudo-random stream of legal RV32I
//  OP-IMM (I-type) instructions and feeds the imem response data of the

---
 rtl/itype_instr_gen.sv | 199 +++++++++++++++++++
 tb/tb_itype_instr_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/itype_instr_gen.sv
// itype_instr_gen
//   Stimulus source for the sodor5_verif harness. It drives the imem response
//   data with a reproducible stream of legal RV32I OP-IMM instructions:
//   WARMUP NOP beats after reset, then NUM_INSTR pseudo-random I-type beats,
//   then it idles with NOP and done=1. The sequence is a pure function of
//   SEED, so core and reference model observe identical traces.
//
// Parameters
//   SEED       initial LFSR state (0 is replaced by 1)
//   NUM_INSTR  random beats before done; 0 = unbounded
//   WARMUP     NOP beats before the first random beat
//
// Ports
//   clk          in   1   clock, rising edge
//   reset_n      in   1   asynchronous active-low reset
//   en           in   1   permits a new beat to be offered
//   instr_ready  in   1   consumer accepts the beat this cycle
//   instr_valid  out  1   instr holds a beat
//   instr        out  32  instruction word
//   done         out  1   NUM_INSTR beats accepted
//   issued_cnt   out  32  random beats accepted since reset
module itype_instr_gen #(
  parameter logic [31:0] SEED      = 32'h00000209,
  parameter int unsigned NUM_INSTR = 100,
  parameter int unsigned WARMUP    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic        done,
  output logic [31:0] issued_cnt
);

  localparam logic [31:0] NOP       = 32'h00000013;
  localparam logic [31:0] LFSR_MASK = 32'h80200003;
  localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] NUM_W     = NUM_INSTR;
  localparam logic [31:0] WARM_W    = WARMUP;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARMUP,
    S_GEN,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] warm_cnt_q, warm_cnt_d;
  logic [31:0] instr_d, issued_cnt_d;
  logic        instr_valid_d, done_d;
  logic        xfer, slot_free;
  logic [31:0] rand_word;

  // Galois form, shifting right: feedback taps applied when bit 0 falls out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

  // Shift-immediate encodings only allow shamt[4:0] plus the SRAI bit 30.
  function automatic logic [31:0] legalize(input logic [31:0] s);
    logic [11:0] imm;
    imm = s[31:20];
    case (s[14:12])
      3'b001:  imm = imm & 12'h01F;
      3'b101:  imm = imm & 12'h41F;
      default: imm = s[31:20];
    endcase
    return {imm, s[19:15], s[14:12], s[11:7], 7'b0010011};
  endfunction

  assign xfer      = instr_valid && instr_ready;
  // The output slot can take a new beat when empty or when its beat leaves now.
  assign slot_free = !instr_valid || xfer;
  assign rand_word = legalize(lfsr_q);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = (WARM_W != '0) ? S_WARMUP : S_GEN;
        end
      end
      S_WARMUP: begin
        if (xfer && (warm_cnt_q + 32'd1 == WARM_W)) begin
          state_d = S_GEN;
        end
      end
      S_GEN: begin
        if (xfer && (NUM_W != '0) && (issued_cnt + 32'd1 == NUM_W)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values. The kind of beat loaded is chosen by the
  // state being entered, so the edge that retires the last NOP already loads
  // the first random beat.
  always_comb begin
    lfsr_d        = lfsr_q;
    warm_cnt_d    = warm_cnt_q;
    instr_d       = instr;
    instr_valid_d = instr_valid;
    done_d        = done;
    issued_cnt_d  = issued_cnt;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          instr_valid_d = 1'b1;
          if (state_d == S_GEN) begin
            instr_d = rand_word;
            lfsr_d  = lfsr_step(lfsr_q);
          end else begin
            instr_d = NOP;
          end
        end
      end
      S_WARMUP: begin
        if (xfer) begin
          warm_cnt_d = warm_cnt_q + 32'd1;
        end
        if (slot_free && en) begin
          instr_valid_d = 1'b1;
          if (state_d == S_GEN) begin
            instr_d = rand_word;
            lfsr_d  = lfsr_step(lfsr_q);
          end else begin
            instr_d = NOP;
          end
        end else if (xfer) begin
          instr_valid_d = 1'b0;
        end
      end
      S_GEN: begin
        if (xfer) begin
          issued_cnt_d = issued_cnt + 32'd1;
        end
        if (state_d == S_DONE) begin
          instr_valid_d = 1'b0;
          instr_d       = NOP;
          done_d        = 1'b1;
        end else if (slot_free && en) begin
          instr_valid_d = 1'b1;
          instr_d       = rand_word;
          lfsr_d        = lfsr_step(lfsr_q);
        end else if (xfer) begin
          instr_valid_d = 1'b0;
        end
      end
      S_DONE: begin
        instr_valid_d = 1'b0;
        instr_d       = NOP;
        done_d        = 1'b1;
      end
      default: begin
        instr_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q      <= SEED_EFF;
      warm_cnt_q  <= '0;
      instr       <= NOP;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      issued_cnt  <= '0;
    end else begin
      lfsr_q      <= lfsr_d;
      warm_cnt_q  <= warm_cnt_d;
      instr       <= instr_d;
      instr_valid <= instr_valid_d;
      done        <= done_d;
      issued_cnt  <= issued_cnt_d;
    end
  end

endmodule

// File: tb/tb_itype_instr_gen.sv
// Directed bench for itype_instr_gen. Four instances share clock and reset:
//   0: default SEED/WARMUP, unbounded stream (reset, stalls, en drop, random run)
//   1: SEED 00501000, WARMUP 0 (slli legalization)
//   2: SEED FFF05000, WARMUP 0 (srai legalization)
//   3: NUM_INSTR 4 (termination)
module tb_itype_instr_gen;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        reset_n;
  logic        en_s [4];
  logic        rdy  [4];
  logic        vld  [4];
  logic [31:0] ins  [4];
  logic        dn   [4];
  logic [31:0] cnt  [4];

  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned m_warm [4];
  logic [31:0] m_lfsr [4];
  logic [31:0] m_cnt  [4];

  itype_instr_gen #(.NUM_INSTR(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .en(en_s[0]), .instr_ready(rdy[0]),
    .instr_valid(vld[0]), .instr(ins[0]), .done(dn[0]), .issued_cnt(cnt[0]));

  itype_instr_gen #(.SEED(32'h00501000), .WARMUP(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .en(en_s[1]), .instr_ready(rdy[1]),
    .instr_valid(vld[1]), .instr(ins[1]), .done(dn[1]), .issued_cnt(cnt[1]));

  itype_instr_gen #(.SEED(32'hFFF05000), .WARMUP(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .en(en_s[2]), .instr_ready(rdy[2]),
    .instr_valid(vld[2]), .instr(ins[2]), .done(dn[2]), .issued_cnt(cnt[2]));

  itype_instr_gen #(.NUM_INSTR(4)) dut3 (
    .clk(clk), .reset_n(reset_n), .en(en_s[3]), .instr_ready(rdy[3]),
    .instr_valid(vld[3]), .instr(ins[3]), .done(dn[3]), .issued_cnt(cnt[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] f_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  function automatic logic [31:0] f_legal(input logic [31:0] s);
    logic [11:0] imm;
    imm = s[31:20];
    if (s[14:12] == 3'd1) imm = imm & 12'h01F;
    if (s[14:12] == 3'd5) imm = imm & 12'h41F;
    return {imm, s[19:7], 7'b0010011};
  endfunction

  task automatic model_reset(input int k, input logic [31:0] seed, input int unsigned warm);
    m_warm[k] = warm;
    m_lfsr[k] = seed;
    m_cnt[k]  = '0;
  endtask

  task automatic model_next(input int k, output logic [31:0] e);
    if (m_warm[k] > 0) begin
      e = NOP;
      m_warm[k] = m_warm[k] - 1;
    end else begin
      e = f_legal(m_lfsr[k]);
      m_lfsr[k] = f_step(m_lfsr[k]);
      m_cnt[k] = m_cnt[k] + 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a beat of instance k to transfer and returns it.
  task automatic get_beat(input int k, output logic [31:0] b);
    bit got;
    got = 0;
    b = '0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (vld[k] && rdy[k]) begin
        b = ins[k];
        got = 1;
      end
      step();
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL beat_timeout inst %0d observed no transfer expected transfer", k);
    end
  endtask

  // Transfer one beat, compare with a hand-computed word, keep the model in step.
  task automatic beat_hand(input int k, input string tag, input logic [31:0] exp);
    logic [31:0] b, e;
    get_beat(k, b);
    model_next(k, e);
    check(tag, b, exp);
  endtask

  task automatic beat_model(input int k, input string tag);
    logic [31:0] b, e;
    get_beat(k, b);
    model_next(k, e);
    check(tag, b, e);
  endtask

  initial begin : stim
    logic [31:0] snap_ins, snap_cnt, e, b;
    logic        pend;
    logic [31:0] pend_ins;
    logic [6:0]  f7;

    reset_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      en_s[k] = 1'b0;
      rdy[k]  = 1'b0;
    end
    model_reset(0, 32'h00000209, 2);
    model_reset(3, 32'h00000209, 2);
    step();
    step();

    // Reset state
    check("rst_valid", {31'b0, vld[0]}, 32'd0);
    check("rst_instr", ins[0], NOP);
    check("rst_done",  {31'b0, dn[0]}, 32'd0);
    check("rst_cnt",   cnt[0], 32'd0);

    // Warmup NOPs then first random beats from SEED 0x209
    reset_n = 1'b1;
    en_s[0] = 1'b1;
    rdy[0]  = 1'b1;
    beat_hand(0, "t2_nop0", NOP);
    beat_hand(0, "t2_nop1", NOP);
    beat_hand(0, "t2_rand0", 32'h00000213);
    beat_hand(0, "t2_rand1", 32'h80200113);
    check("t2_cnt2", cnt[0], 32'd2);
    for (int i = 0; i < 4; i++) beat_model(0, "stream");
    check("stream_cnt", cnt[0], m_cnt[0]);

    // Stall: ready low for 5 cycles holds the pending beat
    rdy[0] = 1'b0;
    check("stall_valid0", {31'b0, vld[0]}, 32'd1);
    snap_ins = ins[0];
    snap_cnt = cnt[0];
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_instr", ins[0], snap_ins);
      check("stall_valid", {31'b0, vld[0]}, 32'd1);
      check("stall_cnt",   cnt[0], snap_cnt);
    end
    rdy[0] = 1'b1;
    beat_model(0, "stall_resume");
    beat_model(0, "stall_next");

    // en falls on a transfer edge: beat completes, slot empties, LFSR holds
    en_s[0] = 1'b0;
    beat_model(0, "enfall_beat");
    check("enfall_valid", {31'b0, vld[0]}, 32'd0);
    check("enfall_cnt", cnt[0], m_cnt[0]);
    step();
    step();
    check("enfall_idle", {31'b0, vld[0]}, 32'd0);
    en_s[0] = 1'b1;
    beat_model(0, "enfall_resume");

    // Asynchronous reset mid-stream
    check("pre_rst_valid", {31'b0, vld[0]}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("t1_valid", {31'b0, vld[0]}, 32'd0);
    check("t1_instr", ins[0], NOP);
    check("t1_cnt",   cnt[0], 32'd0);
    check("t1_done",  {31'b0, dn[0]}, 32'd0);
    step();
    step();
    model_reset(0, 32'h00000209, 2);
    reset_n = 1'b1;
    beat_hand(0, "t1_nop0", NOP);
    beat_hand(0, "t1_nop1", NOP);
    beat_hand(0, "t1_rand0", 32'h00000213);
    beat_hand(0, "t1_rand1", 32'h80200113);
    for (int i = 0; i < 4; i++) beat_model(0, "t1_stream");
    en_s[0] = 1'b0;
    beat_model(0, "t1_last");

    // Shift legalization on the first beat, no warmup
    model_reset(1, 32'h00501000, 0);
    en_s[1] = 1'b1;
    rdy[1]  = 1'b1;
    beat_hand(1, "t3_slli", 32'h00501013);
    en_s[1] = 1'b0;
    model_reset(2, 32'hFFF05000, 0);
    en_s[2] = 1'b1;
    rdy[2]  = 1'b1;
    beat_hand(2, "t3_srai", 32'h41F05013);
    en_s[2] = 1'b0;

    // Bounded run: 2 NOPs + 4 random beats, then terminal DONE
    en_s[3] = 1'b1;
    rdy[3]  = 1'b1;
    beat_hand(3, "t5_nop0", NOP);
    beat_hand(3, "t5_nop1", NOP);
    beat_hand(3, "t5_rand0", 32'h00000213);
    beat_hand(3, "t5_rand1", 32'h80200113);
    beat_model(3, "t5_rand2");
    beat_model(3, "t5_rand3");
    check("t5_done",  {31'b0, dn[3]}, 32'd1);
    check("t5_valid", {31'b0, vld[3]}, 32'd0);
    check("t5_cnt",   cnt[3], 32'd4);
    for (int i = 0; i < 5; i++) step();
    check("t5_done_hold",  {31'b0, dn[3]}, 32'd1);
    check("t5_valid_hold", {31'b0, vld[3]}, 32'd0);
    check("t5_cnt_hold",   cnt[3], 32'd4);
    check("t5_instr_hold", ins[3], NOP);

    // Random en/ready on the unbounded instance
    pend = 1'b0;
    pend_ins = '0;
    for (int c = 0; c < 10000; c++) begin
      if (pend) begin
        check("t6_hold_valid", {31'b0, vld[0]}, 32'd1);
        check("t6_hold_instr", ins[0], pend_ins);
      end
      en_s[0] = ($urandom_range(3) != 0);
      rdy[0]  = ($urandom_range(1) != 0);
      if (vld[0] && rdy[0]) begin
        b = ins[0];
        model_next(0, e);
        check("t6_beat", b, e);
        f7 = b[31:25];
        if (b[14:12] == 3'd1) check("t6_slli_f7", {25'b0, f7}, 32'd0);
        if (b[14:12] == 3'd5) check("t6_sr_f7", {31'b0, (f7 == 7'h00) || (f7 == 7'h20)}, 32'd1);
      end
      pend     = vld[0] && !rdy[0];
      pend_ins = ins[0];
      step();
    end
    check("t6_cnt", cnt[0], m_cnt[0]);
    check("t6_done", {31'b0, dn[0]}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
